// File: rtl/trng_ehr_collector.sv
// Entropy holding register collector: packs de-biased bits MSB-first into 32-bit words
// and buffers them in a small first-word-fall-through FIFO with a sticky overflow flag.
module trng_ehr_collector #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              rng_clk,
    input  logic              rst,
    input  logic              rnd_src_en,
    input  logic              rst_trng_logic,
    input  logic              balance_filter_valid,
    input  logic              balance_filter_data,
    input  logic              ehr_rd_en,
    input  logic              ovf_clr,
    output logic [WORD_W-1:0] ehr_data,
    output logic              ehr_valid,
    output logic              ehr_full,
    output logic [2:0]        ehr_level,
    output logic              ehr_ovf
);

    logic [WORD_W-1:0] r_shift;
    logic [4:0]        r_bitCnt;
    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [1:0]        r_wrPtr;
    logic [1:0]        r_rdPtr;
    logic [2:0]        r_level;
    logic              r_ovf;

    logic              w_accept;
    logic              w_wordDone;
    logic [WORD_W-1:0] w_word;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;

    // The collector clear masks every event, so it is folded into each qualifier.
    assign w_accept   = balance_filter_valid & rnd_src_en & ~rst_trng_logic;
    assign w_wordDone = w_accept & (r_bitCnt == 5'd31);
    assign w_word     = {r_shift[WORD_W-2:0], balance_filter_data};
    assign w_full     = (r_level == 3'(FIFO_DEPTH));
    assign w_empty    = (r_level == 3'd0);
    assign w_pop      = ehr_rd_en & ~w_empty & ~rst_trng_logic;
    assign w_push     = w_wordDone & (~w_full | w_pop);
    assign w_drop     = w_wordDone & w_full & ~w_pop;

    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
        end else if (rst_trng_logic || !rnd_src_en) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
        end else if (w_accept) begin
            r_shift  <= w_word;
            r_bitCnt <= r_bitCnt + 5'd1;
        end
    end

    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (rst_trng_logic) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_word;
                r_wrPtr        <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 3'd1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 3'd1;
            end
        end
    end

    // A same-cycle overflow takes priority over the software clear.
    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (rst_trng_logic) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ehr_data  = w_empty ? '0 : r_mem[r_rdPtr];
    assign ehr_valid = ~w_empty;
    assign ehr_full  = w_full;
    assign ehr_level = r_level;
    assign ehr_ovf   = r_ovf;

endmodule

// File: tb/tb_trng_ehr_collector.sv
// Directed bench for trng_ehr_collector: a table of word/pop/clear operations with
// hand-computed FIFO outputs, plus sequences for coincident and reset corner cases.
module tb_trng_ehr_collector;

    localparam logic [1:0] OP_SEND = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] word;
        logic        expValid;
        logic [31:0] expData;
        logic [2:0]  expLevel;
        logic        expFull;
        logic        expOvf;
    } vecT;

    logic        rng_clk;
    logic        rst;
    logic        rnd_src_en;
    logic        rst_trng_logic;
    logic        balance_filter_valid;
    logic        balance_filter_data;
    logic        ehr_rd_en;
    logic        ovf_clr;
    logic [31:0] ehr_data;
    logic        ehr_valid;
    logic        ehr_full;
    logic [2:0]  ehr_level;
    logic        ehr_ovf;

    int totalCount = 0;
    int badCount   = 0;
    vecT vecs [13];

    trng_ehr_collector dut (
        .rng_clk              (rng_clk),
        .rst                  (rst),
        .rnd_src_en           (rnd_src_en),
        .rst_trng_logic       (rst_trng_logic),
        .balance_filter_valid (balance_filter_valid),
        .balance_filter_data  (balance_filter_data),
        .ehr_rd_en            (ehr_rd_en),
        .ovf_clr              (ovf_clr),
        .ehr_data             (ehr_data),
        .ehr_valid            (ehr_valid),
        .ehr_full             (ehr_full),
        .ehr_level            (ehr_level),
        .ehr_ovf              (ehr_ovf)
    );

    initial rng_clk = 1'b0;
    always #5 rng_clk = ~rng_clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge rng_clk);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic [31:0] expData,
                               input logic [2:0] expLevel, input logic expFull, input logic expOvf);
        checkField({tag, ".valid"}, {31'd0, ehr_valid}, {31'd0, expValid});
        checkField({tag, ".data"},  ehr_data, expData);
        checkField({tag, ".level"}, {29'd0, ehr_level}, {29'd0, expLevel});
        checkField({tag, ".full"},  {31'd0, ehr_full}, {31'd0, expFull});
        checkField({tag, ".ovf"},   {31'd0, ehr_ovf}, {31'd0, expOvf});
    endtask

    task automatic sendBits(input logic [31:0] w, input int nBits, input bit popLast,
                            input bit clrLast, input bit gaps);
        for (int i = 31; i > 31 - nBits; i--) begin
            balance_filter_valid = 1'b1;
            balance_filter_data  = w[i];
            if (i == 32 - nBits) begin
                ehr_rd_en = popLast;
                ovf_clr   = clrLast;
            end
            tick();
            balance_filter_valid = 1'b0;
            balance_filter_data  = 1'b0;
            ehr_rd_en            = 1'b0;
            ovf_clr              = 1'b0;
            if (gaps) tick();
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] word);
        case (op)
            OP_SEND: sendBits(word, 32, 1'b0, 1'b0, 1'b0);
            OP_POP: begin
                ehr_rd_en = 1'b1;
                tick();
                ehr_rd_en = 1'b0;
            end
            default: begin
                ovf_clr = 1'b1;
                tick();
                ovf_clr = 1'b0;
            end
        endcase
    endtask

    task automatic popAndCheck(input string tag, input logic [31:0] expHead);
        checkField({tag, ".head"}, ehr_data, expHead);
        applyStimulus(OP_POP, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{OP_SEND, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{OP_POP,  32'h0,        1'b0, 32'h0,        3'd0, 1'b0, 1'b0};
        vecs[2]  = '{OP_SEND, 32'h1,        1'b1, 32'h1,        3'd1, 1'b0, 1'b0};
        vecs[3]  = '{OP_SEND, 32'h2,        1'b1, 32'h1,        3'd2, 1'b0, 1'b0};
        vecs[4]  = '{OP_SEND, 32'h3,        1'b1, 32'h1,        3'd3, 1'b0, 1'b0};
        vecs[5]  = '{OP_SEND, 32'h4,        1'b1, 32'h1,        3'd4, 1'b1, 1'b0};
        vecs[6]  = '{OP_SEND, 32'h5,        1'b1, 32'h1,        3'd4, 1'b1, 1'b1};
        vecs[7]  = '{OP_POP,  32'h0,        1'b1, 32'h2,        3'd3, 1'b0, 1'b1};
        vecs[8]  = '{OP_POP,  32'h0,        1'b1, 32'h3,        3'd2, 1'b0, 1'b1};
        vecs[9]  = '{OP_POP,  32'h0,        1'b1, 32'h4,        3'd1, 1'b0, 1'b1};
        vecs[10] = '{OP_POP,  32'h0,        1'b0, 32'h0,        3'd0, 1'b0, 1'b1};
        vecs[11] = '{OP_CLR,  32'h0,        1'b0, 32'h0,        3'd0, 1'b0, 1'b0};
        vecs[12] = '{OP_POP,  32'h0,        1'b0, 32'h0,        3'd0, 1'b0, 1'b0};

        rst                  = 1'b1;
        rnd_src_en           = 1'b1;
        rst_trng_logic       = 1'b0;
        balance_filter_valid = 1'b0;
        balance_filter_data  = 1'b0;
        ehr_rd_en            = 1'b0;
        ovf_clr              = 1'b0;
        #12;
        checkOutput("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].op, vecs[v].word);
            checkOutput($sformatf("vec%0d", v), vecs[v].expValid, vecs[v].expData,
                        vecs[v].expLevel, vecs[v].expFull, vecs[v].expOvf);
        end

        // Push and pop at level 0 in the same cycle: only the push takes effect.
        sendBits(32'h0BADF00D, 32, 1'b1, 1'b0, 1'b0);
        checkOutput("pushPopEmpty", 1'b1, 32'h0BADF00D, 3'd1, 1'b0, 1'b0);
        applyStimulus(OP_POP, 32'h0);

        // Idle cycles between accepted bits must not disturb the partial word.
        sendBits(32'h0F0F1234, 32, 1'b0, 1'b0, 1'b1);
        checkOutput("gappedWord", 1'b1, 32'h0F0F1234, 3'd1, 1'b0, 1'b0);
        applyStimulus(OP_POP, 32'h0);

        // Full FIFO, last bit of 0x6 lands with a pop.
        for (int k = 1; k <= 4; k++) applyStimulus(OP_SEND, 32'(k));
        sendBits(32'h6, 32, 1'b1, 1'b0, 1'b0);
        checkOutput("fullPushPop", 1'b1, 32'h2, 3'd4, 1'b1, 1'b0);
        popAndCheck("fpp0", 32'h2);
        popAndCheck("fpp1", 32'h3);
        popAndCheck("fpp2", 32'h4);
        popAndCheck("fpp3", 32'h6);
        checkOutput("fppEmpty", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);

        // Overflow coincident with ovf_clr keeps the flag set.
        for (int k = 7; k <= 10; k++) applyStimulus(OP_SEND, 32'(k));
        sendBits(32'hB, 32, 1'b0, 1'b1, 1'b0);
        checkOutput("ovfVsClr", 1'b1, 32'h7, 3'd4, 1'b1, 1'b1);
        applyStimulus(OP_CLR, 32'h0);
        checkOutput("ovfCleared", 1'b1, 32'h7, 3'd4, 1'b1, 1'b0);
        popAndCheck("ovc0", 32'h7);
        popAndCheck("ovc1", 32'h8);
        popAndCheck("ovc2", 32'h9);
        popAndCheck("ovc3", 32'hA);

        // Partial word abandoned when the source is disabled for one cycle.
        sendBits(32'hFFFFFFFF, 10, 1'b0, 1'b0, 1'b0);
        rnd_src_en           = 1'b0;
        balance_filter_valid = 1'b1;
        balance_filter_data  = 1'b1;
        tick();
        rnd_src_en           = 1'b1;
        balance_filter_valid = 1'b0;
        balance_filter_data  = 1'b0;
        checkOutput("srcOffIdle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        applyStimulus(OP_SEND, 32'hDEADBEEF);
        checkOutput("srcOffWord", 1'b1, 32'hDEADBEEF, 3'd1, 1'b0, 1'b0);
        applyStimulus(OP_POP, 32'h0);

        // Collector clear overrides a same-cycle accept and pop.
        applyStimulus(OP_SEND, 32'h11);
        applyStimulus(OP_SEND, 32'h22);
        applyStimulus(OP_SEND, 32'h33);
        checkOutput("preClear", 1'b1, 32'h11, 3'd3, 1'b0, 1'b0);
        sendBits(32'h12345678, 20, 1'b0, 1'b0, 1'b0);
        rst_trng_logic       = 1'b1;
        balance_filter_valid = 1'b1;
        ehr_rd_en            = 1'b1;
        tick();
        rst_trng_logic       = 1'b0;
        balance_filter_valid = 1'b0;
        ehr_rd_en            = 1'b0;
        checkOutput("logicClear", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        applyStimulus(OP_SEND, 32'hCAFEF00D);
        checkOutput("afterClear", 1'b1, 32'hCAFEF00D, 3'd1, 1'b0, 1'b0);

        // Asynchronous reset between edges, with a partial word in flight.
        applyStimulus(OP_SEND, 32'h44);
        sendBits(32'hFFFFFFFF, 7, 1'b0, 1'b0, 1'b0);
        checkOutput("preAsync", 1'b1, 32'hCAFEF00D, 3'd2, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        tick();
        applyStimulus(OP_SEND, 32'h600DCAFE);
        checkOutput("postAsync", 1'b1, 32'h600DCAFE, 3'd1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/trng_ehr_collector.md
TRNG_EHR_COLLECTOR -- requirements
Module: trng_ehr_collector

Interface
REQ-001 Parameter: WORD_W, 32, width of collected entropy word (fixed; other values not supported).
REQ-002 Parameter: FIFO_DEPTH, 4, number of buffered words (fixed; power of two).
REQ-003 rng_clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rnd_src_en  in  1  entropy source enable; bits accepted only while high.
REQ-006 rst_trng_logic  in  1  synchronous clear of all collector state.
REQ-007 balance_filter_valid  in  1  one-cycle qualifier for balance_filter_data.
REQ-008 balance_filter_data  in  1  de-biased entropy bit from the upstream balance filter.
REQ-009 ehr_rd_en  in  1  pop strobe for FIFO head.
REQ-010 ovf_clr  in  1  synchronous clear of ehr_ovf.
REQ-011 ehr_data  out  32  FIFO head word, first-word-fall-through.
REQ-012 ehr_valid  out  1  FIFO non-empty.
REQ-013 ehr_full  out  1  FIFO holds FIFO_DEPTH words.
REQ-014 ehr_level  out  3  FIFO occupancy, 0..4.
REQ-015 ehr_ovf  out  1  sticky: complete word dropped because FIFO full.

Function
REQ-016 Bit accept: balance_filter_valid & rnd_src_en & !rst_trng_logic; shift_reg <= {shift_reg[30:0], balance_filter_data}; first bit of a word ends in bit 31.
REQ-017 bit_cnt (5 bits) increments per accepted bit; wraps 31 -> 0 on the 32nd bit.
REQ-018 Word complete: accepted bit with bit_cnt==31; push word {shift_reg[30:0], balance_filter_data}.
REQ-019 Push latency: ehr_valid/ehr_data/ehr_level update in the cycle after the 32nd bit's accept edge (registered).
REQ-020 Push while full and no pop same cycle: word dropped, FIFO unchanged, ehr_ovf <= 1.
REQ-021 Push while full with ehr_rd_en same cycle: pop and push both take effect, level stays 4, no overflow.
REQ-022 Pop: ehr_rd_en & ehr_valid removes head; ehr_rd_en while empty ignored, no state change.
REQ-023 Simultaneous push and pop when not full/empty: level unchanged; order preserved (strict FIFO).
REQ-024 Push and pop at level 0 in same cycle: pop ignored, push accepted, level 1.
REQ-025 ehr_data when empty: 32'h0.
REQ-026 rnd_src_en low: partial word discarded (bit_cnt <= 0, shift_reg <= 0) each cycle; FIFO contents and ehr_ovf retained; pops still served.
REQ-027 ovf_clr clears ehr_ovf; an overflow in the same cycle wins (ehr_ovf stays 1).
REQ-028 Read/write pointers are 2-bit, wrap modulo 4; occupancy is 3-bit counter, never exceeds 4 or underflows.

Reset
REQ-029 rst high: shift_reg, bit_cnt, pointers, level, storage, ehr_ovf = 0 immediately; outputs ehr_data=0, ehr_valid=0, ehr_full=0, ehr_level=0, ehr_ovf=0.
REQ-030 rst_trng_logic high: same clear as REQ-029 at next edge; overrides any accept, push, pop or ovf event that cycle.
REQ-031 rst deassertion mid-stream: first accepted bit after release starts a new word at bit_cnt 0.

Verification
REQ-032 32 accepted bits of 0xA5A5A5A5, MSB first -> next cycle ehr_valid=1, ehr_data=32'hA5A5A5A5, ehr_level=1; one pop -> ehr_valid=0, ehr_data=0.
REQ-033 Five words 0x1,0x2,0x3,0x4,0x5 without pops -> ehr_full=1 after 4th, 5th dropped, ehr_ovf=1; four pops return 0x1..0x4; ovf_clr -> ehr_ovf=0.
REQ-034 FIFO full, 32nd bit of 0x6 coincident with ehr_rd_en -> level stays 4, ehr_ovf=0, subsequent pops return 0x2,0x3,0x4,0x6.
REQ-035 10 bits accepted, rnd_src_en low 1 cycle, then 32 bits of 0xDEADBEEF -> exactly one word 32'hDEADBEEF, level=1.
REQ-036 Level 3, 20 bits into next word, rst_trng_logic pulse -> all outputs 0 next cycle; next 32 bits of 0xCAFEF00D -> ehr_data=32'hCAFEF00D, level=1.
REQ-037 rst asserted asynchronously between clock edges with level 2 -> outputs 0 before next rng_clk edge.
